scan_chain_ctrl: RTL and testbench



---
 rtl/scan_chain_ctrl.sv | 133 +++++++++++++
 tb/tb_scan_chain_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan-test sequencer for a single scan chain. It loads a pattern serially,
// issues one capture cycle, unloads the chain, and compares the result under a mask.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 10
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 so,
  output logic                 se,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic [CHAIN_LEN-1:0] unload;
  logic [CHAIN_LEN-1:0] unload_next;

  // The first bit sampled from so ends up in the MSB after CHAIN_LEN shifts.
  always_comb begin
    unload_next = {unload[CHAIN_LEN-2:0], so};
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
      mask_q   <= '0;
      unload   <= '0;
      se       <= 1'b0;
      si       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      response <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        cnt   <= '0;
        se    <= 1'b0;
        si    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              // si is registered, so the MSB goes out now and the rest waits shifted up.
              pat_q    <= pattern << 1;
              exp_q    <= expected;
              mask_q   <= mask;
              pass     <= 1'b0;
              response <= '0;
              se       <= 1'b1;
              si       <= pattern[CHAIN_LEN-1];
              busy     <= 1'b1;
              cnt      <= '0;
              state    <= SHIFT_IN;
            end
          end
          SHIFT_IN: begin
            if (cnt == LAST) begin
              se    <= 1'b0;
              si    <= 1'b0;
              cnt   <= '0;
              state <= CAPTURE;
            end else begin
              si    <= pat_q[CHAIN_LEN-1];
              pat_q <= pat_q << 1;
              cnt   <= cnt + 1'b1;
            end
          end
          CAPTURE: begin
            se    <= 1'b1;
            si    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT_OUT;
          end
          SHIFT_OUT: begin
            unload <= unload_next;
            if (cnt == LAST) begin
              se       <= 1'b0;
              done     <= 1'b1;
              response <= unload_next;
              pass     <= (((unload_next ^ exp_q) & ~mask_q) == '0);
              cnt      <= '0;
              state    <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
          default: begin
            se    <= 1'b0;
            si    <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-flop chain whose capture inverts selected bits,
// plus a timeline reference model that is checked on every falling edge.
module tb_scan_chain_ctrl;
  localparam int CL  = 8;
  localparam int LAT = 2 * CL + 2;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CL-1:0] pattern = '0;
  logic [CL-1:0] expected = '0;
  logic [CL-1:0] mask = '0;
  logic          so;
  logic          se, si, busy, done, pass;
  logic [CL-1:0] response;

  logic [CL-1:0] key = 8'hFF;
  logic [CL-1:0] chain = '0;

  int checks = 0;
  int errors = 0;

  scan_chain_ctrl #(.CHAIN_LEN(CL), .CNT_W(4)) dut (
    .CK(CK), .RN(RN), .start(start), .abort(abort),
    .pattern(pattern), .expected(expected), .mask(mask), .so(so),
    .se(se), .si(si), .busy(busy), .done(done), .pass(pass), .response(response)
  );

  initial forever #5 CK = ~CK;

  // Chain model: shift when se, otherwise capture D = Q ^ key.
  assign so = chain[CL-1];
  initial forever begin
    @(posedge CK);
    if (se) chain <= {chain[CL-2:0], si};
    else    chain <= chain ^ key;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: ph is the cycle index within a test (0 = idle).
  int            ph = 0;
  logic [CL-1:0] m_pat = '0, m_exp = '0, m_mask = '0, m_resp = '0;
  logic          m_pass = 1'b0;

  initial forever begin
    @(posedge CK or negedge RN);
    if (!RN) begin
      ph = 0; m_resp = '0; m_pass = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        ph = 1; m_pat = pattern; m_exp = expected; m_mask = mask;
        m_resp = '0; m_pass = 1'b0;
      end
    end else if (abort || ph == LAT) begin
      ph = 0;
    end else begin
      ph++;
      if (ph == LAT) begin
        m_resp = m_pat ^ key;
        m_pass = (((m_resp ^ m_exp) & ~m_mask) == '0);
      end
    end
  end

  initial forever begin
    @(negedge CK);
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("se", 32'(se), 32'((ph >= 1 && ph <= CL) || (ph >= CL + 2 && ph <= 2 * CL + 1)));
    chk("si", 32'(si), 32'((ph >= 1 && ph <= CL) ? m_pat[CL-ph] : 1'b0));
    chk("done", 32'(done), 32'(ph == LAT));
    if (ph == 0 || ph == LAT) begin
      chk("pass", 32'(pass), 32'(m_pass));
      chk("response", 32'(response), 32'(m_resp));
    end
  end

  // Start from idle at a falling edge; watch until done or a cycle budget expires.
  task automatic run_test(input logic [CL-1:0] p, input logic [CL-1:0] e,
                          input logic [CL-1:0] m, input logic [CL-1:0] k,
                          output int lat, output logic [CL-1:0] si_seq);
    @(negedge CK);
    key = k; pattern = p; expected = e; mask = m; start = 1'b1;
    lat = -1; si_seq = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CK);
      start = 1'b0;
      if (n <= CL) si_seq = {si_seq[CL-2:0], si};
      if (done) begin lat = n; break; end
    end
  endtask

  int            lat;
  logic [CL-1:0] sq;
  int            ndone;
  int            last_done;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CK);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_se", 32'(se), 0);
    chk("rst_resp", 32'(response), 0);
    @(posedge CK); #2 RN = 1'b1;

    // Basic pass
    run_test(8'h5A, 8'hA5, 8'h00, 8'hFF, lat, sq);
    chk("basic_lat", 32'(lat), 18);
    chk("basic_si", 32'(sq), 32'h5A);
    chk("basic_resp", 32'(response), 32'hA5);
    chk("basic_pass", 32'(pass), 1);

    // Fail detect, then masked
    run_test(8'h5A, 8'hA4, 8'h00, 8'hFF, lat, sq);
    chk("fail_pass", 32'(pass), 0);
    chk("fail_resp", 32'(response), 32'hA5);
    run_test(8'h5A, 8'hA4, 8'h01, 8'hFF, lat, sq);
    chk("mask_pass", 32'(pass), 1);

    // Start while busy: pulses at cycles 3 and 12 with a different pattern
    @(negedge CK);
    key = 8'hFF; pattern = 8'h96; expected = 8'h69; mask = '0; start = 1'b1;
    ndone = 0; lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CK);
      start = (n == 3 || n == 12);
      pattern = 8'h0F;
      if (done) begin ndone++; if (lat < 0) lat = n; end
    end
    chk("busy_start_ndone", 32'(ndone), 1);
    chk("busy_start_lat", 32'(lat), 18);
    chk("busy_start_resp", 32'(response), 32'h69);

    // Abort during the first SHIFT_OUT cycle
    @(negedge CK);
    pattern = 8'h3C; expected = 8'hC3; start = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge CK);
      start = 1'b0;
      abort = (n == 10);
      if (n == 11) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_se", 32'(se), 0);
      end
      if (done) ndone++;
    end
    chk("abort_ndone", 32'(ndone), 0);
    run_test(8'hC3, 8'h3C, 8'h00, 8'hFF, lat, sq);
    chk("post_abort_lat", 32'(lat), 18);
    chk("post_abort_pass", 32'(pass), 1);

    // Reset mid-shift-in, asserted off-edge
    @(negedge CK);
    pattern = 8'hFF; start = 1'b1;
    repeat (4) begin @(negedge CK); start = 1'b0; end
    #2 RN = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({se, si, busy, done, pass}), 0);
    chk("mid_rst_resp", 32'(response), 0);
    @(posedge CK); #2 RN = 1'b1;
    run_test(8'h81, 8'h7E, 8'h00, 8'hFF, lat, sq);
    chk("post_rst_lat", 32'(lat), 18);
    chk("post_rst_si", 32'(sq), 32'h81);

    // Back-to-back with start held high
    @(negedge CK);
    key = 8'h0F; start = 1'b1; last_done = -1; ndone = 0;
    for (int n = 1; n <= 5 * (LAT + 1) + 5; n++) begin
      pattern = 8'($urandom); expected = 8'($urandom); mask = 8'($urandom);
      @(negedge CK);
      if (done) begin
        if (last_done < 0) chk("b2b_first", 32'(n), 18);
        else chk("b2b_period", 32'(n - last_done), 19);
        last_done = n; ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(ndone), 5);
    repeat (LAT + 2) @(negedge CK);

    // Randomized tests with stray starts and occasional aborts
    for (int it = 0; it < 40; it++) begin
      int ab;
      logic [CL-1:0] p, m, k;
      ab = int'($urandom_range(0, 30));
      p = 8'($urandom); m = 8'($urandom) & 8'($urandom); k = 8'($urandom);
      @(negedge CK);
      key = k; pattern = p; mask = m; start = 1'b1;
      expected = ($urandom_range(0, 1) == 1) ? ((p ^ k) ^ (8'($urandom) & m)) : 8'($urandom);
      for (int n = 1; n <= LAT + 6; n++) begin
        @(negedge CK);
        start = (n >= 2 && n <= 17 && (ab == 0 || n < ab)) ? ($urandom_range(0, 5) == 0) : 1'b0;
        abort = (n == ab);
        pattern = 8'($urandom);
      end
      abort = 1'b0;
    end

    @(negedge CK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
